// File: rtl/knn_neighbour_vote.sv
// Keeps the K nearest (distance, type) pairs of one inference in a sorted list, then runs a
// majority vote over the kept types and reports the winner with a one-cycle done pulse.
module knn_neighbour_vote #(
  parameter int unsigned K      = 3,
  parameter int unsigned L      = 4,
  parameter int unsigned DIST_W = 32,
  parameter int unsigned TYPE_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DIST_W-1:0] in_dist,
  input  logic [TYPE_W-1:0] in_type,
  input  logic              in_last,
  output logic              busy,
  output logic              done,
  output logic [TYPE_W-1:0] inferred_type,
  output logic              err_empty
);

  localparam int unsigned IdxW = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned CntW = $clog2(K + 1);

  typedef enum logic [1:0] {StIdle, StCollect, StVote, StDone} state_e;

  state_e              state_q, state_d;
  logic [DIST_W-1:0]   dist_q [K];
  logic [DIST_W-1:0]   dist_d [K];
  logic [TYPE_W-1:0]   type_q [K];
  logic [TYPE_W-1:0]   type_d [K];
  logic [K-1:0]        valid_q, valid_d;
  logic [L:0]          cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [CntW-1:0]     best_cnt_q, best_cnt_d;
  logic [TYPE_W-1:0]   best_type_q, best_type_d;
  logic                done_q, done_d;
  logic [TYPE_W-1:0]   inf_q, inf_d;
  logic                err_q, err_d;

  logic                xfer;
  logic [K-1:0]        gt;
  logic [CntW-1:0]     vote_cnt;
  logic [CntW-1:0]     bc;
  logic [TYPE_W-1:0]   bt;

  assign in_ready      = (state_q == StCollect);
  assign busy          = (state_q == StCollect) || (state_q == StVote);
  assign done          = done_q;
  assign inferred_type = inf_q;
  assign err_empty     = err_q;
  assign xfer          = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    dist_d      = dist_q;
    type_d      = type_q;
    valid_d     = valid_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    best_cnt_d  = best_cnt_q;
    best_type_d = best_type_q;
    done_d      = 1'b0;
    inf_d       = inf_q;
    err_d       = err_q;
    gt          = '0;
    vote_cnt    = '0;
    bc          = best_cnt_q;
    bt          = best_type_q;

    // An invalid slot acts as +inf, so gt is a run of zeros followed by ones.
    for (int j = 0; j < K; j++) begin
      gt[j] = !valid_q[j] || (dist_q[j] > in_dist);
    end
    for (int j = 0; j < K; j++) begin
      if (valid_q[j] && (type_q[j] == type_q[idx_q])) vote_cnt = vote_cnt + 1'b1;
    end

    if (start) begin
      state_d    = StCollect;
      valid_d    = '0;
      cnt_d      = '0;
      err_d      = 1'b0;
      idx_d      = '0;
      best_cnt_d = '0;
    end else begin
      unique case (state_q)
        StCollect: begin
          if (xfer) begin
            for (int j = 1; j < K; j++) begin
              if (gt[j]) begin
                if (gt[j-1]) begin
                  dist_d[j]  = dist_q[j-1];
                  type_d[j]  = type_q[j-1];
                  valid_d[j] = valid_q[j-1];
                end else begin
                  dist_d[j]  = in_dist;
                  type_d[j]  = in_type;
                  valid_d[j] = 1'b1;
                end
              end
            end
            if (gt[0]) begin
              dist_d[0]  = in_dist;
              type_d[0]  = in_type;
              valid_d[0] = 1'b1;
            end
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
            if (in_last || (cnt_q == (L+1)'((1 << L) - 1))) begin
              state_d     = StVote;
              idx_d       = '0;
              best_cnt_d  = '0;
              best_type_d = '0;
            end
          end
        end
        StVote: begin
          // Strictly-greater update: ties keep the type that owns the nearer slot.
          if (valid_q[idx_q] && (vote_cnt > bc)) begin
            bc = vote_cnt;
            bt = type_q[idx_q];
          end
          best_cnt_d  = bc;
          best_type_d = bt;
          if (idx_q == IdxW'(K - 1)) begin
            state_d = StDone;
            done_d  = 1'b1;
            inf_d   = valid_q[0] ? bt : '0;
            err_d   = !valid_q[0];
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      best_cnt_q  <= '0;
      best_type_q <= '0;
      done_q      <= 1'b0;
      inf_q       <= '0;
      err_q       <= 1'b0;
      for (int j = 0; j < K; j++) begin
        dist_q[j] <= '0;
        type_q[j] <= '0;
      end
    end else begin
      state_q     <= state_d;
      dist_q      <= dist_d;
      type_q      <= type_d;
      valid_q     <= valid_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      best_cnt_q  <= best_cnt_d;
      best_type_q <= best_type_d;
      done_q      <= done_d;
      inf_q       <= inf_d;
      err_q       <= err_d;
    end
  end

endmodule
